// File: rtl/sh_multi_timer.sv
// sh_multi_timer: shared 13-bit prescaler feeding NCH independent compare/overflow
// counters on the SH DBUS peripheral handshake. Each channel selects its tick rate
// from the prescaler, can clear on compare match, toggle an output pin and raise
// a level interrupt from its match/overflow flags.
module sh_multi_timer #(
    parameter int          NCH   = 2,
    parameter int          CNT_W = 16,
    parameter logic [31:0] BASE  = 32'hFFFFFE40
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE_R,
    input  logic [31:0]      IBUS_A,
    input  logic [31:0]      IBUS_DI,
    output logic [31:0]      IBUS_DO,
    input  logic [3:0]       IBUS_BA,
    input  logic             IBUS_WE,
    input  logic             IBUS_REQ,
    output logic             IBUS_BUSY,
    output logic             IBUS_ACT,
    output logic [NCH-1:0]   TO,
    output logic [NCH-1:0]   IRQ
);
    // One 16-byte block for GSTART plus one per channel.
    localparam logic [31:0] SPAN = 32'(16 * (NCH + 1));

    logic [31:0]    offset;
    logic           in_range;
    logic           wr_en;
    logic [1:0]     word;
    logic [3:0]     blk;
    logic [31:0]    be_mask;
    logic [12:0]    div_cnt_reg;
    logic [NCH-1:0] gstart_reg;
    logic [NCH-1:0] gstart_eff;
    logic           gstart_wr;
    logic [31:0]    ch_rdata [NCH];
    logic [31:0]    rdata;

    // Byte-lane merge of a write into the current register value.
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] be);
        return (old_v & ~be) | (new_v & be);
    endfunction

    // Addresses below BASE wrap to a huge offset and fall outside the range.
    assign offset    = IBUS_A - BASE;
    assign in_range  = offset < SPAN;
    assign word      = offset[3:2];
    assign blk       = offset[7:4];
    assign be_mask   = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}};
    assign wr_en     = IBUS_REQ && IBUS_WE && CE_R && in_range;
    assign IBUS_ACT  = IBUS_REQ && in_range;
    assign IBUS_BUSY = 1'b0;

    // A GSTART write acts in its own cycle, so stopping never lets one more tick through.
    assign gstart_wr  = wr_en && (blk == 4'd0) && (word == 2'd0);
    assign gstart_eff = gstart_wr ? NCH'(merge_be(32'(gstart_reg), IBUS_DI, be_mask)) : gstart_reg;

    // Free-running prescaler, advances on every enabled cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) div_cnt_reg <= '0;
        else if (CE_R) div_cnt_reg <= div_cnt_reg + 13'd1;
    end

    // Global run bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) gstart_reg <= '0;
        else gstart_reg <= gstart_eff;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [3:0] BLK = 4'(gi + 1);
        localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

        logic [7:0]       ctrl_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cmp_reg;
        logic             cmf_reg;
        logic             ovf_reg;
        logic             to_reg;
        logic             sel;
        logic             wr_ctrl, wr_cnt, wr_cmp, wr_stat;
        logic [3:0]       cks;
        logic [12:0]      mask;
        logic             tick, step, match, at_max, clr_on_match;
        logic             clr_cmf, clr_ovf;
        logic [31:0]      ch_val;

        assign sel     = blk == BLK;
        assign wr_ctrl = wr_en && sel && (word == 2'd0);
        assign wr_cnt  = wr_en && sel && (word == 2'd1);
        assign wr_cmp  = wr_en && sel && (word == 2'd2);
        assign wr_stat = wr_en && sel && (word == 2'd3);
        assign clr_cmf = wr_stat && IBUS_BA[0] && IBUS_DI[0];
        assign clr_ovf = wr_stat && IBUS_BA[0] && IBUS_DI[1];

        // CKS saturates at the prescaler width; tick when the low CKS bits are all ones.
        assign cks   = (ctrl_reg[3:0] > 4'd13) ? 4'd13 : ctrl_reg[3:0];
        assign mask  = 13'((14'd1 << cks) - 14'd1);
        assign tick  = CE_R && gstart_eff[gi] && ((div_cnt_reg & mask) == mask);
        // A CPU write to CNT replaces the count step entirely, including match evaluation.
        assign step  = tick && !wr_cnt;
        assign match = cnt_reg == cmp_reg;
        assign at_max = &cnt_reg;
        assign clr_on_match = match && ctrl_reg[4];

        // Channel registers; hardware flag set wins over a same-cycle W1C.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                ctrl_reg <= '0;
                cnt_reg  <= '0;
                cmp_reg  <= '1;
                cmf_reg  <= 1'b0;
                ovf_reg  <= 1'b0;
                to_reg   <= 1'b0;
            end else begin
                if (wr_ctrl) ctrl_reg <= 8'(merge_be(32'(ctrl_reg), IBUS_DI, be_mask));
                if (wr_cmp)  cmp_reg  <= CNT_W'(merge_be(32'(cmp_reg), IBUS_DI, be_mask));
                if (wr_cnt) begin
                    cnt_reg <= CNT_W'(merge_be(32'(cnt_reg), IBUS_DI, be_mask));
                end else if (tick) begin
                    if (clr_on_match) cnt_reg <= '0;
                    else cnt_reg <= cnt_reg + ONE;
                end
                cmf_reg <= (cmf_reg && !clr_cmf) || (step && match);
                ovf_reg <= (ovf_reg && !clr_ovf) || (step && at_max && !clr_on_match);
                if (step && match && ctrl_reg[7]) to_reg <= !to_reg;
            end
        end

        // Per-channel read value, zero unless this block is addressed.
        always_comb begin
            ch_val = '0;
            if (sel) begin
                case (word)
                    2'd0:    ch_val = 32'(ctrl_reg);
                    2'd1:    ch_val = 32'(cnt_reg);
                    2'd2:    ch_val = 32'(cmp_reg);
                    default: ch_val = {30'b0, ovf_reg, cmf_reg};
                endcase
            end
        end

        assign ch_rdata[gi] = ch_val;
        assign TO[gi]  = to_reg;
        assign IRQ[gi] = (cmf_reg && ctrl_reg[5]) || (ovf_reg && ctrl_reg[6]);
    end

    // Read mux: GSTART plus the OR of the channel blocks; bus reads 0 when not a read access.
    always_comb begin
        rdata = '0;
        if ((blk == 4'd0) && (word == 2'd0)) rdata = 32'(gstart_reg);
        for (int i = 0; i < NCH; i++) rdata = rdata | ch_rdata[i];
        IBUS_DO = (IBUS_REQ && !IBUS_WE && in_range) ? rdata : 32'h0;
    end
endmodule

// File: tb/tb_sh_multi_timer.sv
// tb_sh_multi_timer: directed stimulus with a scoreboard; stimulus pushes expected
// read data / pin states into queues and a negedge monitor pops and compares them.
module tb_sh_multi_timer;
    localparam logic [31:0] G = 32'hFFFFFE40;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE_R = 1'b1;
    logic [31:0] IBUS_A = '0;
    logic [31:0] IBUS_DI = '0;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA = 4'hF;
    logic        IBUS_WE = 1'b0;
    logic        IBUS_REQ = 1'b0;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;
    logic [1:0]  TO;
    logic [1:0]  IRQ;

    sh_multi_timer #(.NCH(2), .CNT_W(16), .BASE(G)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .TO(TO), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t pin_q[$];
    int   errors = 0;
    int   checks = 0;
    logic probe = 1'b0;

    function automatic logic [31:0] ch(input int c, input int w);
        return G + 32'(16 * (c + 1)) + 32'(4 * w);
    endfunction

    function automatic logic [31:0] pins(input logic act, input logic [1:0] t, input logic [1:0] q);
        return {26'b0, 1'b0, act, t, q};
    endfunction

    // Monitor: compare whenever the bench presents a read or a pin probe.
    always @(negedge CLK) begin : mon
        exp_t e;
        logic [31:0] got;
        if (IBUS_REQ && !IBUS_WE) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got=%h exp=<none>", IBUS_DO);
            end else begin
                e = rd_q.pop_front();
                if (IBUS_DO !== e.val) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h", e.name, IBUS_DO, e.val);
                end else $display("ok   %s read=%h", e.name, IBUS_DO);
            end
        end
        if (probe) begin
            checks++;
            got = {26'b0, IBUS_BUSY, IBUS_ACT, TO, IRQ};
            if (pin_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_probe got=%h exp=<none>", got);
            end else begin
                e = pin_q.pop_front();
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h (busy,act,to,irq)", e.name, got, e.val);
                end else $display("ok   %s pins=%h", e.name, got);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
        IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        @(posedge CLK); #1;
        IBUS_REQ = 1'b0; IBUS_WE = 1'b0; IBUS_BA = 4'hF;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_v, input string nm);
        rd_q.push_back('{nm, exp_v});
        IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        IBUS_REQ = 1'b0;
    endtask

    task automatic chk_pins(input logic act, input logic [1:0] t, input logic [1:0] q, input string nm);
        pin_q.push_back('{nm, pins(act, t, q)});
        probe = 1'b1;
        @(negedge CLK); #1;
        probe = 1'b0;
    endtask

    // Read and probe in the same sampling instant (used while reset is held).
    task automatic rd_probe(input logic [31:0] a, input logic [31:0] exp_v, input logic act, input string nm);
        rd_q.push_back('{nm, exp_v});
        pin_q.push_back('{{nm, "_pins"}, pins(act, 2'b00, 2'b00)});
        IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1; probe = 1'b1;
        @(negedge CLK); #1;
        IBUS_REQ = 1'b0; probe = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        // Reset state
        chk_pins(1'b0, 2'b00, 2'b00, "rst_pins");
        rd_probe(ch(0, 2), 32'h0000FFFF, 1'b1, "rst_cmp0");
        rd_probe(G + 32'h30, 32'h0, 1'b0, "rst_oor");
        @(posedge CLK); #1;
        RST = 1'b0;
        rd(ch(0, 1), 32'h0, "rst_cnt0");
        rd(ch(1, 3), 32'h0, "rst_stat1");
        rd(ch(1, 2), 32'h0000FFFF, "rst_cmp1");
        rd(G, 32'h0, "rst_gstart");

        // 1: CKS=0, CMP=4, CCLR, TOE, CMIE
        wr(ch(0, 2), 32'd4, 4'hF);
        wr(ch(0, 0), 32'hB0, 4'hF);
        wr(G, 32'h1, 4'hF); idle(2); wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'd3, "t1_cnt3");
        wr(G, 32'h1, 4'hF); wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'd4, "t1_cnt4");
        rd(ch(0, 3), 32'd0, "t1_nocmf");
        wr(G, 32'h1, 4'hF); wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'd0, "t1_wrap");
        rd(ch(0, 3), 32'd1, "t1_cmf");
        chk_pins(1'b0, 2'b01, 2'b01, "t1_pins");
        wr(ch(0, 3), 32'h1, 4'hF);
        rd(ch(0, 3), 32'd0, "t1_w1c");
        chk_pins(1'b0, 2'b01, 2'b00, "t1_irq_clr");
        wr(G, 32'h1, 4'hF); idle(4); wr(G, 32'h0, 4'hF);
        chk_pins(1'b0, 2'b00, 2'b01, "t1_toggle2");

        // 2: overflow with CMP=all ones, both flags together
        wr(ch(0, 0), 32'h60, 4'hF);
        wr(ch(0, 3), 32'h3, 4'hF);
        wr(ch(0, 2), 32'hFFFFFFFF, 4'hF);
        rd(ch(0, 2), 32'h0000FFFF, "t2_cmp");
        wr(ch(0, 1), 32'hFFFE, 4'hF);
        wr(G, 32'h1, 4'hF); wr(G, 32'h0, 4'hF);
        rd(ch(0, 3), 32'd0, "t2_pre");
        wr(G, 32'h1, 4'hF); wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'd0, "t2_cnt");
        rd(ch(0, 3), 32'd3, "t2_both");
        chk_pins(1'b0, 2'b00, 2'b01, "t2_pins");

        // 3: W1C of OVF collides with a new overflow
        wr(ch(0, 0), 32'h40, 4'hF);
        wr(ch(0, 1), 32'hFFFE, 4'hF);
        wr(G, 32'h1, 4'hF);
        wr(ch(0, 3), 32'h2, 4'hF);
        wr(G, 32'h0, 4'hF);
        rd(ch(0, 3), 32'd3, "t3_collide");
        chk_pins(1'b0, 2'b00, 2'b01, "t3_irq1");
        wr(ch(0, 3), 32'h2, 4'hF);
        rd(ch(0, 3), 32'd1, "t3_ovf_clr");
        chk_pins(1'b0, 2'b00, 2'b00, "t3_irq0");

        // 4: CNT write beats tick; CMP write applies from the next tick; byte enables
        wr(ch(0, 0), 32'h0, 4'hF);
        wr(ch(0, 2), 32'd5, 4'hF);
        wr(ch(0, 1), 32'd3, 4'hF);
        wr(G, 32'h1, 4'hF);
        wr(ch(0, 1), 32'h1234, 4'hF);
        wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'h1234, "t4_cnt_wr");
        wr(ch(0, 0), 32'h10, 4'hF);
        wr(ch(0, 1), 32'd3, 4'hF);
        wr(G, 32'h1, 4'hF);
        wr(ch(0, 2), 32'd4, 4'hF);
        wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'd5, "t4_cmp_old");
        rd(ch(0, 2), 32'd4, "t4_cmp_new");
        wr(ch(0, 2), 32'hAAAA5555, 4'b0011);
        rd(ch(0, 2), 32'h00005555, "t4_be_low");
        wr(ch(0, 2), 32'h000077EE, 4'b0010);
        rd(ch(0, 2), 32'h00007755, "t4_be_byte1");
        wr(G + 32'h8, 32'hFFFFFFFF, 4'hF);
        rd(G + 32'h8, 32'h0, "t4_unmapped");
        rd(G, 32'h0, "t4_gstart");

        // 5: two channels, CKS 0 and 2, 8 enabled cycles with a CE_R gap
        wr(ch(0, 0), 32'h0, 4'hF);
        wr(ch(0, 1), 32'h0, 4'hF);
        wr(ch(1, 0), 32'h2, 4'hF);
        wr(ch(1, 1), 32'h0, 4'hF);
        wr(G, 32'h3, 4'hF); idle(3);
        CE_R = 1'b0;
        wr(ch(0, 1), 32'h99, 4'hF);
        idle(4);
        CE_R = 1'b1;
        idle(4); wr(G, 32'h0, 4'hF);
        rd(ch(0, 1), 32'd8, "t5_cnt0");
        rd(ch(1, 1), 32'd2, "t5_cnt1");
        idle(5);
        rd(ch(0, 1), 32'd8, "t5_hold0");
        wr(ch(1, 0), 32'h3, 4'hF);
        wr(ch(1, 1), 32'h0, 4'hF);
        wr(G, 32'h2, 4'hF); idle(15); wr(G, 32'h0, 4'hF);
        rd(ch(1, 1), 32'd2, "t5_cks3");
        rd(ch(0, 1), 32'd8, "t5_ch0_idle");

        // 6: reset while counting with CMF=1, TO=1
        wr(ch(0, 0), 32'hB0, 4'hF);
        wr(ch(0, 2), 32'h0, 4'hF);
        wr(ch(0, 1), 32'h0, 4'hF);
        wr(G, 32'h1, 4'hF);
        chk_pins(1'b0, 2'b01, 2'b01, "t6_pre");
        RST = 1'b1;
        #1;
        chk_pins(1'b0, 2'b00, 2'b00, "t6_rst_pins");
        rd_probe(ch(0, 2), 32'h0000FFFF, 1'b1, "t6_rst_cmp");
        rd_probe(G + 32'h40, 32'h0, 1'b0, "t6_rst_oor");
        rd_probe(ch(0, 3), 32'h0, 1'b1, "t6_rst_stat");
        @(posedge CLK); #1;
        RST = 1'b0;
        rd(ch(0, 1), 32'h0, "t6_cnt");
        rd(ch(0, 0), 32'h0, "t6_ctrl");
        rd(G, 32'h0, "t6_gstart");
        chk_pins(1'b0, 2'b00, 2'b00, "t6_after");

        idle(3);
        while (rd_q.size() > 0) begin
            exp_t e;
            e = rd_q.pop_front();
            checks++; errors++;
            $display("FAIL %s got=<no read> exp=%h", e.name, e.val);
        end
        while (pin_q.size() > 0) begin
            exp_t e;
            e = pin_q.pop_front();
            checks++; errors++;
            $display("FAIL %s got=<no probe> exp=%h", e.name, e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
